apb_master_ctrl: RTL and testbench

APB master controller that sequences host read/write requests onto the shared APB bus and arbitrates access between two 128-word APB memory slaves. It sits between a simple valid/ready host request port and the slave instances. It decodes the target slave from the address, runs the IDLE/SETUP/ACCESS protocol, tolerates wait states via PREADY, and returns read data or an error on a one-cycle response strobe.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_master_ctrl_if.sv | 25 ++
 rtl/apb_addr_decode.sv | 22 ++
 rtl/apb_master_ctrl.sv | 168 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master controller and its address decoder:
// state encodings, slave-select codes and the saturating wait-counter helper.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] SEL_S1 = 2'b00;
  localparam logic [1:0] SEL_S2 = 2'b01;

  localparam int SLAVE_IDX_W = 7;
  localparam int WAIT_CNT_W  = 8;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus between the master controller and its two memory slaves.
interface apb_master_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             PSEL1;
  logic             PSEL2;
  logic             PENABLE;
  logic             PWRITE;
  logic [WIDTH-1:0] PADDR;
  logic [WIDTH-1:0] PWDATA;
  logic             PREADY1;
  logic             PREADY2;
  logic [WIDTH-1:0] PRDATA1;
  logic [WIDTH-1:0] PRDATA2;

  modport master (
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY1, PREADY2, PRDATA1, PRDATA2
  );

  modport slave (
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY1, PREADY2, PRDATA1, PRDATA2
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Pure decode of the slave-select address bits into a one-hot select
// (bit 0 = slave1, bit 1 = slave2) plus a decode-error flag.
module apb_addr_decode
  import apb_pkg::*;
(
  input  logic [1:0] sel_bits,
  output logic [1:0] sel_onehot,
  output logic       dec_err
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    sel_onehot = 2'b00;
    dec_err    = 1'b0;
    case (sel_bits)
      SEL_S1:  sel_onehot = 2'b01;
      SEL_S2:  sel_onehot = 2'b10;
      default: dec_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: accepts host requests, runs SETUP/ACCESS on one of two slaves,
// and returns a one-cycle response strobe. All outputs come straight from flops.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  apb_master_ctrl_if.master  apb
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  psel1_q, psel1_d;
  logic                  psel2_q, psel2_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [WIDTH-1:0]      paddr_q, paddr_d;
  logic [WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0]            dec_sel;
  logic                  dec_err;
  logic                  pready_sel;
  logic [WIDTH-1:0]      prdata_sel;
  logic                  unused_addr_bits;

  apb_addr_decode u_decode (
    .sel_bits   (req_addr[SLAVE_IDX_W+1:SLAVE_IDX_W]),
    .sel_onehot (dec_sel),
    .dec_err    (dec_err)
  );

  assign unused_addr_bits = ^req_addr[WIDTH-1:SLAVE_IDX_W+2];

  // Only the selected slave's handshake matters; the other is don't-care.
  assign pready_sel = psel1_q ? apb.PREADY1 : apb.PREADY2;
  assign prdata_sel = psel1_q ? apb.PRDATA1 : apb.PRDATA2;

  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        // req_ready_q gates acceptance so nothing is taken in the first cycle after reset.
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          pwrite_d    = req_write;
          paddr_d     = {{(WIDTH-SLAVE_IDX_W){1'b0}}, req_addr[SLAVE_IDX_W-1:0]};
          pwdata_d    = req_wdata;
          if (dec_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = ST_SETUP;
            psel1_d    = dec_sel[0];
            psel2_d    = dec_sel[1];
            wait_cnt_d = '0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (pready_sel) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
        end else begin
          wait_cnt_d = sat_inc(wait_cnt_q);
          if (wait_cnt_d >= TIMEOUT_C) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            psel1_d     = 1'b0;
            psel2_d     = 1'b0;
            penable_d   = 1'b0;
          end
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign apb.PSEL1   = psel1_q;
  assign apb.PSEL2   = psel2_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: two memory slaves with programmable
// wait states, and a transaction-level reference model of memories and timing.
module tb_apb_master_ctrl;

  localparam int TIMEOUT = 15;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  apb_master_ctrl_if #(.WIDTH(32)) apb ();

  apb_master_ctrl #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 PCLK = ~PCLK;

  // Slave models: wait_cfg wait states per access; unselected slaves drive junk.
  int          wait_cfg = 0;
  int          wcnt1 = 0;
  int          wcnt2 = 0;
  logic [31:0] s_mem1 [128] = '{default: '0};
  logic [31:0] s_mem2 [128] = '{default: '0};

  assign apb.PREADY1 = apb.PSEL1 ? (apb.PENABLE && wcnt1 == 0) : 1'b1;
  assign apb.PREADY2 = apb.PSEL2 ? (apb.PENABLE && wcnt2 == 0) : 1'b1;
  assign apb.PRDATA1 = (apb.PSEL1 && apb.PENABLE) ? s_mem1[apb.PADDR[6:0]] : 32'hA5A5_A5A5;
  assign apb.PRDATA2 = (apb.PSEL2 && apb.PENABLE) ? s_mem2[apb.PADDR[6:0]] : 32'h5A5A_5A5A;

  always @(posedge PCLK) begin
    if (apb.PSEL1 && !apb.PENABLE) wcnt1 <= wait_cfg;
    else if (apb.PSEL1 && apb.PENABLE && wcnt1 != 0) wcnt1 <= wcnt1 - 1;
    if (apb.PSEL2 && !apb.PENABLE) wcnt2 <= wait_cfg;
    else if (apb.PSEL2 && apb.PENABLE && wcnt2 != 0) wcnt2 <= wcnt2 - 1;
    if (apb.PSEL1 && apb.PENABLE && apb.PREADY1 && apb.PWRITE) s_mem1[apb.PADDR[6:0]] <= apb.PWDATA;
    if (apb.PSEL2 && apb.PENABLE && apb.PREADY2 && apb.PWRITE) s_mem2[apb.PADDR[6:0]] <= apb.PWDATA;
  end

  // Reference model: what each slave should hold after completed writes.
  logic [31:0] ref_mem1 [128] = '{default: '0};
  logic [31:0] ref_mem2 [128] = '{default: '0};

  // Runs one transfer from a negedge; returns at the negedge of the IDLE cycle after RESP.
  // hold keeps req_valid high throughout (host holding the next request).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input bit hold, input string tag);
    int          slave, n, cyc, acc, exp_lat, exp_acc;
    bit          exp_err, bad_overlap, bad_sel, bad_phase, bad_stable, bad_ready;
    logic [31:0] exp_rdata;
    logic [6:0]  idx;

    idx   = addr[6:0];
    slave = int'(addr[8:7]);
    if (slave >= 2) begin
      exp_err = 1'b1; exp_acc = 0; exp_lat = 1; exp_rdata = '0;
    end else if (waits >= TIMEOUT) begin
      exp_err = 1'b1; exp_acc = TIMEOUT; exp_lat = 2 + TIMEOUT; exp_rdata = '0;
    end else begin
      exp_err = 1'b0; exp_acc = waits + 1; exp_lat = 2 + exp_acc;
      if (wr) begin
        exp_rdata = '0;
        if (slave == 0) ref_mem1[idx] = wdata; else ref_mem2[idx] = wdata;
      end else begin
        exp_rdata = (slave == 0) ? ref_mem1[idx] : ref_mem2[idx];
      end
    end

    req_write = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1; wait_cfg = waits;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge PCLK); n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b required 1 within 40 cycles", tag, req_ready);
      req_valid = 1'b0;
      return;
    end

    @(posedge PCLK);
    @(negedge PCLK);
    if (!hold) req_valid = 1'b0;
    cyc = 1; acc = 0;
    bad_overlap = 0; bad_sel = 0; bad_phase = 0; bad_stable = 0; bad_ready = 0;
    while (rsp_valid !== 1'b1 && cyc < 400) begin
      if (apb.PSEL1 === 1'b1 && apb.PSEL2 === 1'b1) bad_overlap = 1;
      if (apb.PSEL1 !== (slave == 0) || apb.PSEL2 !== (slave == 1)) bad_sel = 1;
      if (apb.PENABLE !== (cyc != 1)) bad_phase = 1;
      if (apb.PADDR !== {25'b0, idx} || apb.PWDATA !== wdata || apb.PWRITE !== wr) bad_stable = 1;
      if (req_ready !== 1'b0) bad_ready = 1;
      if (apb.PENABLE === 1'b1) acc++;
      @(negedge PCLK); cyc++;
    end

    checks++;
    if (cyc != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d cycles required %0d", tag, cyc, exp_lat);
    end
    checks++;
    if (bad_overlap) begin
      errors++; $display("FAIL %s psel_overlap: PSEL1 and PSEL2 both high, required exclusive", tag);
    end
    checks++;
    if (bad_sel) begin
      errors++; $display("FAIL %s psel: wrong slave select seen, required slave %0d", tag, slave);
    end
    checks++;
    if (bad_phase) begin
      errors++; $display("FAIL %s penable: wrong SETUP/ACCESS phase, required 0 then 1", tag);
    end
    checks++;
    if (bad_stable) begin
      errors++; $display("FAIL %s stable: PADDR/PWDATA/PWRITE not held, required %h/%h/%b", tag, {25'b0, idx}, wdata, wr);
    end
    checks++;
    if (bad_ready) begin
      errors++; $display("FAIL %s req_ready: high during transfer, required 0", tag);
    end
    checks++;
    if (acc != exp_acc) begin
      errors++; $display("FAIL %s access_cycles: got %0d required %0d", tag, acc, exp_acc);
    end
    checks++;
    if (rsp_err !== exp_err) begin
      errors++; $display("FAIL %s rsp_err: got %b required %b", tag, rsp_err, exp_err);
    end
    checks++;
    if (rsp_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rsp_rdata: got %h required %h", tag, rsp_rdata, exp_rdata);
    end
    checks++;
    if ({apb.PSEL1, apb.PSEL2, apb.PENABLE} !== 3'b000) begin
      errors++; $display("FAIL %s resp_bus: PSEL1/PSEL2/PENABLE=%b required 000", tag, {apb.PSEL1, apb.PSEL2, apb.PENABLE});
    end

    @(negedge PCLK);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_resp: rsp_valid=%b req_ready=%b required 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  function automatic bit all_outputs_zero();
    return {req_ready, rsp_valid, rsp_err, rsp_rdata, apb.PSEL1, apb.PSEL2, apb.PENABLE,
            apb.PWRITE, apb.PADDR, apb.PWDATA} === '0;
  endfunction

  task automatic test_reset();
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge PCLK);
    checks++;
    if (!all_outputs_zero()) begin
      errors++; $display("FAIL reset_outputs: outputs not all zero during reset, req_ready=%b", req_ready);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_slave_select();
    run_txn(1'b1, 32'h085, 32'h1234_5678, 0, 1'b0, "wr_s2");
    run_txn(1'b0, 32'h005, 32'h0,         1, 1'b0, "rd_s1_empty");
    run_txn(1'b0, 32'h085, 32'h0,         0, 1'b0, "rd_s2");
    run_txn(1'b1, 32'h005, 32'hDEAD_BEEF, 2, 1'b0, "wr_s1");
    run_txn(1'b0, 32'h005, 32'h0,         1, 1'b0, "rd_s1");
  endtask

  task automatic test_decode_error();
    run_txn(1'b0, 32'h105, 32'h0,         0, 1'b0, "dec_err_rd");
    run_txn(1'b1, 32'h185, 32'hCAFE_F00D, 0, 1'b0, "dec_err_wr");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h005, 32'h0,         200,         1'b0, "timeout_rd");
    run_txn(1'b1, 32'h0A0, 32'hBAD0_0001, TIMEOUT,     1'b0, "timeout_wr");
    run_txn(1'b0, 32'h0A0, 32'h0,         TIMEOUT - 1, 1'b0, "last_wait_rd");
    run_txn(1'b0, 32'h005, 32'h0,         0,           1'b0, "rd_after_timeout");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = {23'b0, 2'(i % 2), 7'($urandom_range(0, 15))};
      run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b1, "b2b");
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          r, w;
      logic [1:0]  sel;
      logic [31:0] a;
      r   = $urandom_range(0, 9);
      sel = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'($urandom_range(2, 3));
      a   = {23'b0, sel, 7'($urandom_range(0, 15))};
      w   = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 3) : $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), a, $urandom, w, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_access();
    int  n;
    bit  saw_rsp;
    req_write = 1'b0; req_addr = 32'h07F; req_wdata = '0; wait_cfg = 200; req_valid = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    n = 0;
    while (apb.PENABLE !== 1'b1 && n < 10) begin
      @(negedge PCLK); n++;
    end
    checks++;
    if (apb.PENABLE !== 1'b1) begin
      errors++; $display("FAIL midreset_reach_access: PENABLE=%b required 1", apb.PENABLE);
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (!all_outputs_zero()) begin
      errors++; $display("FAIL midreset_async: outputs not zero immediately, PSEL1=%b PENABLE=%b", apb.PSEL1, apb.PENABLE);
    end
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    PRESETn = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      errors++; $display("FAIL midreset_no_rsp: rsp_valid seen for aborted request, required none");
    end
    run_txn(1'b1, 32'h07F, 32'h0BAD_CAFE, 1, 1'b0, "post_reset_wr");
    run_txn(1'b0, 32'h07F, 32'h0,         0, 1'b0, "post_reset_rd");
  endtask

  initial begin
    test_reset();
    test_slave_select();
    test_decode_error();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
